// File: rtl/contador_modulo_n.sv
// Parametrised modulo-N up/down counter built from JK-semantic state cells.
// J/K excitation is derived from the next state and exposed for observation.
module contador_modulo_n #(
   parameter int          WIDTH  = 3,
   parameter int unsigned MODULO = 7,
   parameter int unsigned INIT   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             tc,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

   logic [WIDTH-1:0] nxt;
   logic             d_ok;
   logic             at_end;

   // MODULO may equal 2**WIDTH, so the legality check is done in 32 bits
   assign d_ok   = 32'(d) < MODULO;
   assign at_end = up ? (q == MAXV) : (q == '0);
   assign tc     = en & ~load & at_end;

   always_comb begin
      nxt = q;
      if (load)
         nxt = d_ok ? d : '0;
      else if (en) begin
         if (up)
            nxt = at_end ? '0 : q + WIDTH'(1);
         else
            nxt = at_end ? MAXV : q - WIDTH'(1);
      end
   end

   assign j  = ~q & nxt;
   assign k  = q & ~nxt;
   assign nq = ~q;

   // each state bit behaves as a JK flip-flop driven by j/k
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= INIT_V;
      else begin
         for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
               2'b10:   q[i] <= 1'b1;
               2'b01:   q[i] <= 1'b0;
               2'b11:   q[i] <= ~q[i];
               default: q[i] <= q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         wrap <= tc;
         if (load && !d_ok)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_contador_modulo_n.sv
// Scoreboard bench for contador_modulo_n: default mod-7 instance plus a 4-bit mod-16 instance.
module tb_contador_modulo_n;

   typedef struct {
      logic [2:0] q;
      logic       wrap;
      logic       err;
   } exp_t;

   typedef struct {
      logic [3:0] q;
      logic       wrap;
   } exp2_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up, load;
   logic [2:0] d;
   logic [2:0] q, nq, j, k;
   logic       tc, wrap, err;

   logic       en2, up2, load2;
   logic [3:0] d2;
   logic [3:0] q2, nq2, j2, k2;
   logic       tc2, wrap2, err2;

   int   n_chk = 0;
   int   n_fail = 0;
   int   mq;
   bit   mw, me;
   exp_t  sb[$];
   exp2_t sb2[$];

   always #5 clk = ~clk;

   contador_modulo_n dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
      .q(q), .nq(nq), .j(j), .k(k), .tc(tc), .wrap(wrap), .err(err)
   );

   contador_modulo_n #(.WIDTH(4), .MODULO(16), .INIT(15)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .up(up2), .load(load2), .d(d2),
      .q(q2), .nq(nq2), .j(j2), .k(k2), .tc(tc2), .wrap(wrap2), .err(err2)
   );

   // drive one edge of stimulus; the model pushes what the DUT must show after it
   task automatic step(input bit l, input logic [2:0] dv, input bit e, input bit u);
      int n;
      bit w;
      load = l; d = dv; en = e; up = u;
      w = 1'b0;
      n = mq;
      if (l) begin
         if (int'(dv) < 7) n = int'(dv);
         else begin n = 0; me = 1'b1; end
      end else if (e) begin
         if (u) begin w = (mq == 6); n = w ? 0 : mq + 1; end
         else   begin w = (mq == 0); n = w ? 6 : mq - 1; end
      end
      mq = n; mw = w;
      sb.push_back('{q: 3'(n), wrap: w, err: me});
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mq = 0; mw = 1'b0; me = 1'b0;
      sb.delete();
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
      en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; d2 = '0;
      mq = 0; mw = 1'b0; me = 1'b0;
      #12;
      n_chk++;
      if ({q, nq, wrap, err} !== {3'd0, 3'd7, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got q=%0d nq=%0d wrap=%b err=%b, want q=0 nq=7 wrap=0 err=0", q, nq, wrap, err);
      end
      n_chk++;
      if ({q2, wrap2, err2} !== {4'd15, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_wide: got q=%0d wrap=%b err=%b, want q=15 wrap=0 err=0", q2, wrap2, err2);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_count_up();
      int wraps = 0;
      exp_t e;
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 3'd0, 1'b1, 1'b1);
         e = sb.pop_front();
         wraps += int'(wrap);
         n_chk++;
         if ({q, nq, wrap, err} !== {e.q, ~e.q, e.wrap, e.err}) begin
            n_fail++;
            $display("FAIL count_up[%0d]: got q=%0d nq=%0d wrap=%b err=%b, want q=%0d nq=%0d wrap=%b err=%b",
                     i, q, nq, wrap, err, e.q, ~e.q, e.wrap, e.err);
         end
      end
      n_chk++;
      if (wraps != 2) begin
         n_fail++;
         $display("FAIL count_up_wraps: got %0d wrap cycles, want 2", wraps);
      end
   endtask

   task automatic test_count_down();
      exp_t e;
      en = 1'b1; up = 1'b0; load = 1'b0; #1;
      n_chk++;
      if (tc !== 1'b1 || q !== 3'd0) begin
         n_fail++;
         $display("FAIL down_tc: got tc=%b q=%0d, want tc=1 q=0", tc, q);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 3'd0, 1'b1, 1'b0);
         e = sb.pop_front();
         n_chk++;
         if ({q, wrap, tc} !== {e.q, e.wrap, (e.q == 3'd0)}) begin
            n_fail++;
            $display("FAIL count_down[%0d]: got q=%0d wrap=%b tc=%b, want q=%0d wrap=%b tc=%b",
                     i, q, wrap, tc, e.q, e.wrap, (e.q == 3'd0));
         end
      end
   endtask

   task automatic test_load_err();
      exp_t e;
      step(1'b1, 3'd5, 1'b1, 1'b1);
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, err} !== {3'd5, 1'b0, 1'b0} || e.q !== 3'd5) begin
         n_fail++;
         $display("FAIL load_legal: got q=%0d wrap=%b err=%b, want q=5 wrap=0 err=0", q, wrap, err);
      end
      step(1'b1, 3'd7, 1'b1, 1'b1);
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, err} !== {e.q, e.wrap, e.err}) begin
         n_fail++;
         $display("FAIL load_illegal: got q=%0d wrap=%b err=%b, want q=%0d wrap=%b err=%b",
                  q, wrap, err, e.q, e.wrap, e.err);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 3'd0, 1'b1, i[0]);
         e = sb.pop_front();
         n_chk++;
         if ({q, wrap, err} !== {e.q, e.wrap, e.err}) begin
            n_fail++;
            $display("FAIL err_sticky[%0d]: got q=%0d wrap=%b err=%b, want q=%0d wrap=%b err=%b",
                     i, q, wrap, err, e.q, e.wrap, e.err);
         end
      end
      do_reset();
      n_chk++;
      if ({q, err} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL err_clear: got q=%0d err=%b, want q=0 err=0", q, err);
      end
   endtask

   task automatic test_jk();
      exp_t e;
      step(1'b1, 3'd3, 1'b0, 1'b1);
      e = sb.pop_front();
      load = 1'b0; en = 1'b1; up = 1'b1; #1;
      n_chk++;
      if ({q, j, k, tc} !== {e.q, 3'b100, 3'b011, 1'b0}) begin
         n_fail++;
         $display("FAIL jk_up: got q=%0d j=%b k=%b tc=%b, want q=%0d j=100 k=011 tc=0", q, j, k, tc, e.q);
      end
      en = 1'b0; #1;
      n_chk++;
      if ({j, k} !== 6'b0) begin
         n_fail++;
         $display("FAIL jk_hold: got j=%b k=%b, want j=000 k=000", j, k);
      end
      step(1'b0, 3'd0, 1'b0, 1'b1);
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap} !== {e.q, e.wrap}) begin
         n_fail++;
         $display("FAIL hold: got q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, e.q, e.wrap);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      step(1'b1, 3'd6, 1'b0, 1'b1);
      void'(sb.pop_front());
      step(1'b0, 3'd0, 1'b1, 1'b1);
      void'(sb.pop_front());
      step(1'b1, 3'd4, 1'b0, 1'b1);
      void'(sb.pop_front());
      en = 1'b1; load = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({q, wrap, err} !== {3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got q=%0d wrap=%b err=%b, want q=0 wrap=0 err=0", q, wrap, err);
      end
      mq = 0; mw = 1'b0; me = 1'b0;
      sb.delete();
      #1 rst_n = 1'b1;
      step(1'b0, 3'd0, 1'b1, 1'b1);
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap} !== {e.q, e.wrap}) begin
         n_fail++;
         $display("FAIL restart: got q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, e.q, e.wrap);
      end
   endtask

   task automatic test_wide();
      int m2;
      int wraps = 0;
      exp2_t e;
      do_reset();
      m2 = 15;
      en = 1'b0; load = 1'b0;
      en2 = 1'b1; up2 = 1'b1; load2 = 1'b0;
      for (int i = 0; i < 17; i++) begin
         sb2.push_back('{q: 4'((m2 + 1) % 16), wrap: (m2 == 15)});
         m2 = (m2 + 1) % 16;
         @(posedge clk); #1;
         e = sb2.pop_front();
         wraps += int'(wrap2);
         n_chk++;
         if ({q2, nq2, wrap2, err2} !== {e.q, ~e.q, e.wrap, 1'b0}) begin
            n_fail++;
            $display("FAIL wide[%0d]: got q=%0d wrap=%b err=%b, want q=%0d wrap=%b err=0",
                     i, q2, wrap2, err2, e.q, e.wrap);
         end
      end
      n_chk++;
      if (wraps != 2) begin
         n_fail++;
         $display("FAIL wide_period: got %0d wrap cycles in 17 edges, want 2", wraps);
      end
      en2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load_err();
      test_jk();
      test_async_reset();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
